// File: rtl/dp_ram16k_fifo_ctrl_pkg.sv
// Shared geometry and types for the K6N10 BRAM (DP_RAM16K) exposed as a 512x32 buffer.
package qlf_k6n10_bram_pkg;
    localparam int BRAM_DEPTH = 512;
    localparam int BRAM_AW    = 9;
    localparam int BRAM_DW    = 32;
    localparam int BRAM_CW    = 10;

    typedef logic [BRAM_AW-1:0] bram_addr_t;
    typedef logic [BRAM_DW-1:0] bram_data_t;
    typedef logic [BRAM_CW-1:0] bram_cnt_t;
endpackage

// File: rtl/dp_ram16k_fifo_ctrl_bram_ptr.sv
// 9-bit wrapping RAM address pointer with async reset, sync clear and increment.
module bram_ptr
    import qlf_k6n10_bram_pkg::*;
(
    input  logic       clk,
    input  logic       R,
    input  logic       i_clr,
    input  logic       i_inc,
    output bram_addr_t o_ptr
);

    bram_addr_t r_ptr;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge R) begin
        if (R) begin
            r_ptr <= '0;
        end else if (i_clr) begin
            r_ptr <= '0;
        end else if (i_inc) begin
            r_ptr <= r_ptr + 1'b1;
        end
    end

    assign o_ptr = r_ptr;

endmodule

// File: rtl/dp_ram16k_fifo_ctrl.sv
// Valid/ready FIFO controller driving both ports of one DP_RAM16K; the RAM output register is the head stage.
module dp_ram16k_fifo_ctrl
    import qlf_k6n10_bram_pkg::*;
#(
    parameter int DEPTH  = BRAM_DEPTH,
    parameter int DATA_W = BRAM_DW
) (
    input  logic              clk,
    input  logic              R,
    input  logic              flush,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_valid,
    output logic              s_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              m_valid,
    input  logic              m_ready,
    output bram_cnt_t         count,
    output bram_addr_t        ram_waddr,
    output logic [DATA_W-1:0] ram_d_in,
    output logic              ram_wen,
    output logic [DATA_W-1:0] ram_wenb,
    output bram_addr_t        ram_raddr,
    output logic              ram_ren,
    input  logic [DATA_W-1:0] ram_d_out
);

    bram_cnt_t  r_mem_cnt;
    logic       r_m_valid;
    logic       w_full;
    logic       w_push;
    logic       w_fetch;
    bram_addr_t w_wptr;
    bram_addr_t w_rptr;

    // Full is judged on mem_cnt alone, so m_ready never reaches s_ready combinationally.
    assign w_full  = (r_mem_cnt == BRAM_CW'(DEPTH));
    assign s_ready = ~w_full & ~flush & ~R;
    assign w_push  = s_valid & s_ready;
    assign w_fetch = (r_mem_cnt != '0) & (~r_m_valid | m_ready) & ~flush;

    bram_ptr u_wptr (
        .clk   (clk),
        .R     (R),
        .i_clr (flush),
        .i_inc (w_push),
        .o_ptr (w_wptr)
    );

    bram_ptr u_rptr (
        .clk   (clk),
        .R     (R),
        .i_clr (flush),
        .i_inc (w_fetch),
        .o_ptr (w_rptr)
    );

    always_ff @(posedge clk or posedge R) begin
        if (R) begin
            r_mem_cnt <= '0;
            r_m_valid <= 1'b0;
        end else if (flush) begin
            r_mem_cnt <= '0;
            r_m_valid <= 1'b0;
        end else begin
            unique case ({w_push, w_fetch})
                2'b10:   r_mem_cnt <= r_mem_cnt + 10'd1;
                2'b01:   r_mem_cnt <= r_mem_cnt - 10'd1;
                default: r_mem_cnt <= r_mem_cnt;
            endcase
            if (w_fetch) begin
                r_m_valid <= 1'b1;
            end else if (r_m_valid & m_ready) begin
                r_m_valid <= 1'b0;
            end
        end
    end

    assign ram_wen   = ~w_push;
    assign ram_waddr = w_wptr;
    assign ram_d_in  = s_data;
    assign ram_wenb  = '1;
    assign ram_ren   = ~w_fetch;
    assign ram_raddr = w_rptr;

    assign m_data  = ram_d_out;
    assign m_valid = r_m_valid;
    assign count   = r_mem_cnt + {9'd0, r_m_valid};

endmodule

// File: tb/tb_dp_ram16k_fifo_ctrl.sv
// Bench for dp_ram16k_fifo_ctrl: behavioural RAM plus a queue-based FIFO reference model.
module tb_dp_ram16k_fifo_ctrl;

    logic        clk     = 1'b0;
    logic        R       = 1'b0;
    logic        flush   = 1'b0;
    logic [31:0] s_data  = '0;
    logic        s_valid = 1'b0;
    logic        m_ready = 1'b0;
    logic        s_ready;
    logic [31:0] m_data;
    logic        m_valid;
    logic [9:0]  count;
    logic [8:0]  ram_waddr;
    logic [31:0] ram_d_in;
    logic        ram_wen;
    logic [31:0] ram_wenb;
    logic [8:0]  ram_raddr;
    logic        ram_ren;
    logic [31:0] ram_d_out = '0;

    always #5 clk = ~clk;

    dp_ram16k_fifo_ctrl dut (
        .clk       (clk),
        .R         (R),
        .flush     (flush),
        .s_data    (s_data),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .m_data    (m_data),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .count     (count),
        .ram_waddr (ram_waddr),
        .ram_d_in  (ram_d_in),
        .ram_wen   (ram_wen),
        .ram_wenb  (ram_wenb),
        .ram_raddr (ram_raddr),
        .ram_ren   (ram_ren),
        .ram_d_out (ram_d_out)
    );

    // DP_RAM16K behaviour: registered read, old data on same-address read-during-write.
    logic [31:0] ram_mem [512];
    always @(posedge clk) begin
        if (!ram_wen) ram_mem[ram_waddr] <= ram_d_in;
        if (!ram_ren) ram_d_out <= ram_mem[ram_raddr];
    end

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] q[$];
    bit          hv = 1'b0;
    logic [31:0] hd = '0;
    int          w_idx = 0;
    int          r_idx = 0;
    bit          last_push = 1'b0;
    bit          seq_mode = 1'b0;
    int          seq_next = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        q.delete();
        hv    = 1'b0;
        w_idx = 0;
        r_idx = 0;
    endtask

    task automatic drive(input bit f, input bit sv, input bit mr, input logic [31:0] d);
        flush   = f;
        s_valid = sv;
        m_ready = mr;
        s_data  = d;
        #1;
    endtask

    task automatic check_model();
        int sz;
        bit can_push;
        bit can_fetch;
        sz        = q.size();
        can_push  = (sz != 512) && !flush;
        can_fetch = (sz != 0) && (!hv || m_ready) && !flush;
        check("count", 32'(count), 32'(sz + int'(hv)));
        check("s_ready", 32'(s_ready), 32'(can_push));
        check("m_valid", 32'(m_valid), 32'(hv));
        if (hv) check("m_data", m_data, hd);
        check("ram_wen", 32'(ram_wen), 32'(!(s_valid && can_push)));
        check("ram_ren", 32'(ram_ren), 32'(!can_fetch));
        check("ram_waddr", 32'(ram_waddr), 32'(w_idx % 512));
        check("ram_raddr", 32'(ram_raddr), 32'(r_idx % 512));
        check("ram_d_in", ram_d_in, s_data);
        check("ram_wenb", ram_wenb, 32'hFFFF_FFFF);
        if (seq_mode && hv && m_ready && !flush) begin
            check("pop_order", m_data, 32'(seq_next));
            seq_next++;
        end
    endtask

    task automatic tick();
        int sz;
        bit push_m;
        bit fetch_m;
        @(posedge clk);
        sz        = q.size();
        push_m    = !R && s_valid && (sz != 512) && !flush;
        fetch_m   = !R && (sz != 0) && (!hv || m_ready) && !flush;
        last_push = push_m;
        if (R || flush) begin
            model_clear();
        end else begin
            if (fetch_m) begin
                hd = q.pop_front();
                hv = 1'b1;
                r_idx++;
            end else if (hv && m_ready) begin
                hv = 1'b0;
            end
            if (push_m) begin
                q.push_back(s_data);
                w_idx++;
            end
        end
        @(negedge clk);
    endtask

    task automatic cycle(input bit f, input bit sv, input bit mr, input logic [31:0] d);
        drive(f, sv, mr, d);
        if (!R) check_model();
        tick();
    endtask

    typedef struct {
        bit          sv;
        bit          mr;
        logic [31:0] d;
        bit          e_rdy;
        bit          e_mv;
        logic [31:0] e_md;
        int          e_cnt;
        bit          e_wen;
        bit          e_ren;
    } vec_t;

    vec_t vecs[4];

    initial begin
        int          budget;
        logic [31:0] next_val;

        vecs[0] = '{1'b1, 1'b0, 32'hDEADBEEF, 1'b1, 1'b0, 32'h0,        0, 1'b0, 1'b1};
        vecs[1] = '{1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 32'h0,        1, 1'b1, 1'b0};
        vecs[2] = '{1'b0, 1'b1, 32'h0,        1'b1, 1'b1, 32'hDEADBEEF, 1, 1'b1, 1'b1};
        vecs[3] = '{1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 32'h0,        0, 1'b1, 1'b1};

        // Power-on reset with a push request held to show the write port stays idle.
        s_valid = 1'b1;
        #2 R = 1'b1;
        #1;
        check("rst_s_ready", 32'(s_ready), 32'd0);
        check("rst_m_valid", 32'(m_valid), 32'd0);
        check("rst_count", 32'(count), 32'd0);
        check("rst_wen", 32'(ram_wen), 32'd1);
        check("rst_ren", 32'(ram_ren), 32'd1);
        check("rst_waddr", 32'(ram_waddr), 32'd0);
        check("rst_raddr", 32'(ram_raddr), 32'd0);
        repeat (2) @(negedge clk);
        R = 1'b0;
        s_valid = 1'b0;
        model_clear();
        #1 check("rel_s_ready", 32'(s_ready), 32'd1);

        // Single word through an empty FIFO.
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, vecs[i].sv, vecs[i].mr, vecs[i].d);
            check($sformatf("vec%0d_s_ready", i), 32'(s_ready), 32'(vecs[i].e_rdy));
            check($sformatf("vec%0d_m_valid", i), 32'(m_valid), 32'(vecs[i].e_mv));
            if (vecs[i].e_mv) check($sformatf("vec%0d_m_data", i), m_data, vecs[i].e_md);
            check($sformatf("vec%0d_count", i), 32'(count), 32'(vecs[i].e_cnt));
            check($sformatf("vec%0d_wen", i), 32'(ram_wen), 32'(vecs[i].e_wen));
            check($sformatf("vec%0d_ren", i), 32'(ram_ren), 32'(vecs[i].e_ren));
            check_model();
            tick();
        end

        // Fill to capacity with the consumer stalled, then drain in order.
        next_val = 0;
        budget   = 0;
        while (next_val < 513 && budget < 600) begin
            cycle(1'b0, 1'b1, 1'b0, next_val);
            if (last_push) next_val++;
            budget++;
        end
        drive(1'b0, 1'b1, 1'b0, 32'hFFFF);
        check("full_count", 32'(count), 32'd513);
        check("full_s_ready", 32'(s_ready), 32'd0);
        check("full_wen", 32'(ram_wen), 32'd1);
        tick();
        seq_mode = 1'b1;
        seq_next = 0;
        budget   = 0;
        while ((q.size() != 0 || hv) && budget < 700) begin
            cycle(1'b0, 1'b0, 1'b1, 32'h0);
            budget++;
        end
        seq_mode = 1'b0;
        check("fill_pops", 32'(seq_next), 32'd513);
        drive(1'b0, 1'b0, 1'b0, 32'h0);
        check("fill_empty_count", 32'(count), 32'd0);

        // Wrap-around stream with random backpressure on both sides.
        seq_mode = 1'b1;
        seq_next = 0;
        next_val = 0;
        budget   = 0;
        while (seq_next < 2000 && budget < 20000) begin
            cycle(1'b0, (next_val < 2000) && ($urandom_range(0, 3) != 0),
                  $urandom_range(0, 2) != 0, next_val);
            if (last_push) next_val++;
            budget++;
        end
        seq_mode = 1'b0;
        check("wrap_pops", 32'(seq_next), 32'd2000);
        drive(1'b0, 1'b0, 1'b0, 32'h0);
        check("wrap_empty_count", 32'(count), 32'd0);

        // Steady concurrent traffic at occupancy 5.
        budget = 0;
        while ((q.size() + int'(hv)) < 5 && budget < 20) begin
            cycle(1'b0, 1'b1, 1'b0, $urandom);
            budget++;
        end
        cycle(1'b0, 1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 20; i++) begin
            drive(1'b0, 1'b1, 1'b1, $urandom);
            check("conc_count", 32'(count), 32'd5);
            check("conc_m_valid", 32'(m_valid), 32'd1);
            check_model();
            tick();
        end
        budget = 0;
        while ((q.size() != 0 || hv) && budget < 20) begin
            cycle(1'b0, 1'b0, 1'b1, 32'h0);
            budget++;
        end

        // Flush at occupancy 100, then a fresh word must survive.
        budget = 0;
        while ((q.size() + int'(hv)) < 100 && budget < 200) begin
            cycle(1'b0, 1'b1, 1'b0, $urandom);
            budget++;
        end
        drive(1'b1, 1'b1, 1'b1, 32'hBAD0);
        check("flush_count_before", 32'(count), 32'd100);
        check("flush_s_ready", 32'(s_ready), 32'd0);
        check("flush_wen", 32'(ram_wen), 32'd1);
        check("flush_ren", 32'(ram_ren), 32'd1);
        tick();
        drive(1'b0, 1'b0, 1'b0, 32'h0);
        check("post_flush_count", 32'(count), 32'd0);
        check("post_flush_m_valid", 32'(m_valid), 32'd0);
        check_model();
        tick();
        cycle(1'b0, 1'b1, 1'b0, 32'h1234);
        cycle(1'b0, 1'b0, 1'b0, 32'h0);
        drive(1'b0, 1'b0, 1'b1, 32'h0);
        check("flush_pop_valid", 32'(m_valid), 32'd1);
        check("flush_pop_data", m_data, 32'h1234);
        tick();

        // Reset in the middle of random traffic.
        for (int i = 0; i < 40; i++) begin
            cycle(1'b0, $urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0, $urandom);
        end
        s_valid = 1'b1;
        m_ready = 1'b1;
        R       = 1'b1;
        #1;
        check("mid_rst_m_valid", 32'(m_valid), 32'd0);
        check("mid_rst_count", 32'(count), 32'd0);
        check("mid_rst_wen", 32'(ram_wen), 32'd1);
        check("mid_rst_ren", 32'(ram_ren), 32'd1);
        check("mid_rst_s_ready", 32'(s_ready), 32'd0);
        check("mid_rst_waddr", 32'(ram_waddr), 32'd0);
        tick();
        tick();
        R = 1'b0;
        model_clear();
        drive(1'b0, 1'b1, 1'b0, 32'hA5A5_5A5A);
        check("rel_first_waddr", 32'(ram_waddr), 32'd0);
        check("rel_first_wen", 32'(ram_wen), 32'd0);
        check_model();
        tick();
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 1'b1, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
